layer_23_bwd: RTL
=================

# layer_23_bwd

Backward (error-propagation) counterpart of the layer-23 output neuron. It accepts one signed 8-bit error delta on the neuron output and streams the ten per-input gradients `delta * w_i` back toward the ten layer-23 inputs. It reuses the forward weights and a single time-multiplexed multiplier. It sits between the loss/error stage and the layer-22 backward path, behind valid/ready handshakes on both sides.

## Interface
- `N_IN`, 10, number of inputs and gradients per delta
- `DW`, 8, delta width (signed)
- `WW`, 10, weight width (signed)
- `GW`, 9, gradient width (signed; matches forward input width)
- `SHIFT`, 9, arithmetic right shift applied to the product
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `delta_valid`  in  1  delta offered
- `delta_ready`  out  1  block can accept a delta (registered)
- `delta`  in  DW  signed error on neuron output
- `grad_valid`  out  1  gradient word valid
- `grad_ready`  in  1  downstream accepts gradient
- `grad`  out  GW  signed gradient for input `grad_idx+1`
- `grad_idx`  out  4  0..9, index of the gradient
- `grad_last`  out  1  high with `grad_idx`==9

## Operation
- Weights are fixed and identical to the forward neuron. As signed decimals, w0..w9 are 219, -27, -182, 193, 23, 12, 322, -121, -332, -118.
- FSM has two states:
  - IDLE: `delta_ready`=1. On `delta_valid && delta_ready`, latch `delta` into `delta_q`, load the output for index 0, set `grad_valid`=1, and go to RUN. `delta_ready` drops in the same edge.
  - RUN: on `grad_valid && grad_ready` with `grad_idx`<9, load the output for `grad_idx+1`. On the handshake with `grad_idx`==9, clear `grad_valid` and `grad_last`, and go to IDLE. `delta_ready` returns to 1 on that edge.
- Gradient arithmetic:
  - P = delta × w_i, full 18-bit signed product.
  - `grad` = P >>> SHIFT, i.e. P[17:9], floor (truncation toward −inf).
  - No overflow is possible: |P| ≤ 65536, so the result lies in −128..128.
- While `grad_valid`=1 and `grad_ready`=0, `grad`, `grad_idx` and `grad_last` hold stable.
- `delta_valid` is ignored in RUN. There is no queueing.

## Timing
- Reset values:
  - `delta_ready`=0, `grad_valid`=0, `grad`=0, `grad_idx`=0, `grad_last`=0, state IDLE.
  - `delta_ready`=1 on the first edge with `rst_n`=1.
- Latency: a delta accepted at edge k gives index 0 valid after edge k (1 cycle).
- With `grad_ready` tied high, indices 0..9 appear on 10 consecutive cycles. `delta_ready` is high in the following cycle.
- Minimum delta period is 11 cycles.
- Reset asserted mid-burst aborts the burst. All outputs go to reset values at that edge, and the partial burst is discarded.
- All outputs are registered. No combinational path exists from `grad_ready` or `delta_valid` to any output.

## Configuration
- `GRAD_ROUND_EN` defined: `grad` = (P + 2^(SHIFT−1)) >>> SHIFT, i.e. round half up. This needs a 19-bit intermediate and still cannot overflow GW.
- `GRAD_ROUND_EN` undefined: plain floor truncation as above. This is the default and is bit-matched to the forward block's truncation.

## Structure
- Package `layer23_pkg` holds:
  - the widths N_IN, DW, WW, GW and SHIFT;
  - the 10-entry weight constant array shared with the forward neuron;
  - the FSM state enum.
- Sub-module `layer_23_wrom` is a combinational index → weight lookup, so the weight source is shared by the forward and backward paths.
- Top level holds the FSM, index counter, `delta_q`, the single multiplier and the output registers.

## Test plan
- delta=1, `grad_ready`=1:
  - indices 1,2,7,8,9 → `grad`=−1 (9'h1FF);
  - all other indices → 0;
  - `grad_last` only on idx 9.
- delta=127:
  - idx0 → 54 and idx8 → −83;
  - with `GRAD_ROUND_EN`: idx0 → 54 and idx8 → −82.
- delta=−128: idx8 → 83, idx0 → −55, idx6 → −81.
- Backpressure: `grad_ready`=0 for 5 cycles at idx 3 → `grad`, `grad_idx`=3 and `grad_valid` are stable. The burst then finishes with idx 4..9 in order.
- `rst_n` low for 1 cycle at idx 5:
  - all outputs 0 after that edge;
  - `delta_ready`=1 one cycle after release;
  - the next delta starts at idx 0.
- `delta_valid` held high with two distinct deltas:
  - the second is accepted exactly 1 cycle after the first burst's idx-9 handshake;
  - `delta` changes during RUN have no effect.

Source files
------------

// File: rtl/layer23_pkg.sv
// Shared constants for the layer-23 neuron (forward and backward paths):
// widths, the fixed weight table and the backward FSM state encoding.
package layer23_pkg;

  localparam int unsigned N_IN  = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 10;
  localparam int unsigned GW    = 9;
  localparam int unsigned SHIFT = 9;
  localparam int unsigned IW    = 4;
  localparam int unsigned PW    = DW + WW;
  localparam int unsigned RW    = PW + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  // Weights w0..w9, identical to the forward neuron.
  localparam logic signed [WW-1:0] W_ROM [N_IN] = '{
    10'sd219, -10'sd27, -10'sd182, 10'sd193, 10'sd23,
    10'sd12,  10'sd322, -10'sd121, -10'sd332, -10'sd118
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/layer_23_wrom.sv
// Combinational index -> weight lookup shared by forward and backward paths.
module layer_23_wrom
  import layer23_pkg::*;
(
  input  logic        [IW-1:0] idx_i,
  output logic signed [WW-1:0] weight_o
);

  // Out-of-range indices read as zero.
  always_comb begin
    weight_o = '0;
    if (idx_i <= LAST_IDX) weight_o = W_ROM[idx_i];
  end

endmodule

// File: rtl/layer_23_bwd.sv
// Backward pass of the layer-23 output neuron: one delta in, ten gradients
// delta*w_i >>> SHIFT streamed out through a single shared multiplier.
// Optional macro GRAD_ROUND_EN selects round-half-up instead of floor.
module layer_23_bwd
  import layer23_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          delta_valid,
  output logic          delta_ready,
  input  logic [DW-1:0] delta,
  output logic          grad_valid,
  input  logic          grad_ready,
  output logic [GW-1:0] grad,
  output logic [3:0]    grad_idx,
  output logic          grad_last
);

  state_e         state_q, state_d;
  logic [DW-1:0]  delta_q, delta_d;
  logic [GW-1:0]  grad_q, grad_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           ready_q, ready_d;

  logic signed [DW-1:0] mul_delta_c;
  logic        [IW-1:0] mul_idx_c;
  logic signed [WW-1:0] weight_c;
  logic signed [PW-1:0] prod_c;
  logic        [GW-1:0] grad_c;

  // Multiplier operands: fresh delta for index 0, latched delta afterwards.
  always_comb begin
    mul_delta_c = delta_q;
    mul_idx_c   = idx_q + IW'(1);
    if (state_q == IDLE) begin
      mul_delta_c = delta;
      mul_idx_c   = '0;
    end
  end

  layer_23_wrom u_wrom (
    .idx_i    (mul_idx_c),
    .weight_o (weight_c)
  );

  assign prod_c = mul_delta_c * weight_c;

`ifdef GRAD_ROUND_EN
  localparam logic signed [RW-1:0] RND_HALF = RW'(1) << (SHIFT - 1);
  logic signed [RW-1:0] sum_c;
  assign sum_c  = {prod_c[PW-1], prod_c} + RND_HALF;
  assign grad_c = GW'(sum_c >>> SHIFT);
`else
  assign grad_c = GW'(prod_c >>> SHIFT);
`endif

  // Next-state and output-register update.
  always_comb begin
    state_d = state_q;
    delta_d = delta_q;
    grad_d  = grad_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (delta_valid && ready_q) begin
          delta_d = delta;
          grad_d  = grad_c;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && grad_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = mul_idx_c;
            grad_d = grad_c;
            last_d = (mul_idx_c == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      delta_q <= '0;
      grad_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      delta_q <= delta_d;
      grad_q  <= grad_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign delta_ready = ready_q;
  assign grad_valid  = valid_q;
  assign grad        = grad_q;
  assign grad_idx    = idx_q;
  assign grad_last   = last_q;

endmodule
